// File: rtl/mem_wb_if.sv
// MEM->WB stage bundle: the upstream entry handshake plus the downstream
// WB handshake, grouped so the stage and its environment connect as one port.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// exactly when valid && ready are both high. A producer holding valid high
// keeps its payload stable until the transfer happens; ready may be
// asserted without valid and carries no obligation on its own.
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) ();

  // Upstream (MEM) side
  logic              in_valid;
  logic              in_ready;
  logic [RD_W-1:0]   in_rd;
  logic              in_im_to_rf;
  logic              in_load;
  logic [DATA_W-1:0] in_alu_data;
  logic [DATA_W-1:0] in_dm_data;

  // Downstream (WB) side
  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic              out_im_to_rf;
  logic              out_load;
  logic [DATA_W-1:0] out_alu_data;
  logic [DATA_W-1:0] out_dm_data;
  logic [DATA_W-1:0] out_wb_data;

  // Environment view: produces MEM entries, consumes WB entries
  modport master (
    output in_valid, in_rd, in_im_to_rf, in_load, in_alu_data, in_dm_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_rd, out_im_to_rf, out_load, out_alu_data,
    input  out_dm_data, out_wb_data
  );

  // Stage view: accepts MEM entries, presents WB entries
  modport slave (
    input  in_valid, in_rd, in_im_to_rf, in_load, in_alu_data, in_dm_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_rd, out_im_to_rf, out_load, out_alu_data,
    output out_dm_data, out_wb_data
  );

endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register. With SKID=1 a second (skid) entry S sits behind
// the main entry M so in_ready is a pure register output and never depends
// on out_ready; with SKID=0 the stage is a single register whose in_ready
// is combinational. M always drives the WB-facing fields.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int SKID   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  mem_wb_if.slave     bus,
  output logic [1:0]  occupancy
);

  // Main entry M
  logic              m_valid_q, m_valid_d;
  logic [RD_W-1:0]   m_rd_q,    m_rd_d;
  logic              m_wr_q,    m_wr_d;
  logic              m_load_q,  m_load_d;
  logic [DATA_W-1:0] m_alu_q,   m_alu_d;
  logic [DATA_W-1:0] m_dm_q,    m_dm_d;

  // Skid entry S (stays empty when SKID=0)
  logic              s_valid_q, s_valid_d;
  logic [RD_W-1:0]   s_rd_q,    s_rd_d;
  logic              s_wr_q,    s_wr_d;
  logic              s_load_q,  s_load_d;
  logic [DATA_W-1:0] s_alu_q,   s_alu_d;
  logic [DATA_W-1:0] s_dm_q,    s_dm_d;

  logic in_ready;
  logic accept;
  logic m_free;

  // Upstream ready: skid variant only looks at its own S register
  always_comb begin
    if (SKID != 0) begin
      in_ready = !s_valid_q;
    end else begin
      in_ready = !m_valid_q || bus.out_ready;
    end
  end

  assign accept = bus.in_valid && in_ready;
  // M may take a new value this edge: it is empty or its entry retires
  assign m_free = !m_valid_q || bus.out_ready;

  // Next-state for M and S; flush outranks accept and retire
  always_comb begin
    m_valid_d = m_valid_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    m_load_d  = m_load_q;
    m_alu_d   = m_alu_q;
    m_dm_d    = m_dm_q;
    s_valid_d = s_valid_q;
    s_rd_d    = s_rd_q;
    s_wr_d    = s_wr_q;
    s_load_d  = s_load_q;
    s_alu_d   = s_alu_q;
    s_dm_d    = s_dm_q;

    if (flush) begin
      // Payloads are left as-is; only the valid bits are killed
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (m_free) begin
        if (s_valid_q) begin
          // Oldest waiting entry is in S; it moves up first
          m_valid_d = 1'b1;
          m_rd_d    = s_rd_q;
          m_wr_d    = s_wr_q;
          m_load_d  = s_load_q;
          m_alu_d   = s_alu_q;
          m_dm_d    = s_dm_q;
        end else if (accept) begin
          m_valid_d = 1'b1;
          m_rd_d    = bus.in_rd;
          m_wr_d    = bus.in_im_to_rf;
          m_load_d  = bus.in_load;
          m_alu_d   = bus.in_alu_data;
          m_dm_d    = bus.in_dm_data;
        end else begin
          m_valid_d = 1'b0;
        end
        s_valid_d = 1'b0;
      end else if (accept) begin
        // M is stalled; park the new entry in S
        s_valid_d = 1'b1;
        s_rd_d    = bus.in_rd;
        s_wr_d    = bus.in_im_to_rf;
        s_load_d  = bus.in_load;
        s_alu_d   = bus.in_alu_data;
        s_dm_d    = bus.in_dm_data;
      end
    end else begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_rd_d    = bus.in_rd;
        m_wr_d    = bus.in_im_to_rf;
        m_load_d  = bus.in_load;
        m_alu_d   = bus.in_alu_data;
        m_dm_d    = bus.in_dm_data;
      end else if (bus.out_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset clears valid bits and every payload field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_rd_q    <= '0;
      m_wr_q    <= 1'b0;
      m_load_q  <= 1'b0;
      m_alu_q   <= '0;
      m_dm_q    <= '0;
      s_valid_q <= 1'b0;
      s_rd_q    <= '0;
      s_wr_q    <= 1'b0;
      s_load_q  <= 1'b0;
      s_alu_q   <= '0;
      s_dm_q    <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_load_q  <= m_load_d;
      m_alu_q   <= m_alu_d;
      m_dm_q    <= m_dm_d;
      s_valid_q <= s_valid_d;
      s_rd_q    <= s_rd_d;
      s_wr_q    <= s_wr_d;
      s_load_q  <= s_load_d;
      s_alu_q   <= s_alu_d;
      s_dm_q    <= s_dm_d;
    end
  end

  // WB-facing outputs: control fields read as a bubble when M is empty,
  // data fields keep their last value
  always_comb begin
    bus.in_ready     = in_ready;
    bus.out_valid    = m_valid_q;
    bus.out_rd       = m_valid_q ? m_rd_q : '0;
    bus.out_im_to_rf = m_valid_q && m_wr_q;
    bus.out_load     = m_valid_q && m_load_q;
    bus.out_alu_data = m_alu_q;
    bus.out_dm_data  = m_dm_q;
    bus.out_wb_data  = (m_valid_q && m_load_q) ? m_dm_q : m_alu_q;
  end

  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: one skid (SKID=1) and one plain (SKID=0) instance
// driven with identical stimulus, directed scenarios plus a randomized run
// scored against a queue-based model of each stage.
module tb_mem_wb_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = RW + 2 + 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush;
  always #5 clk = ~clk;

  mem_wb_if #(.DATA_W(DW), .RD_W(RW)) b1 ();
  mem_wb_if #(.DATA_W(DW), .RD_W(RW)) b0 ();
  logic [1:0] occ1, occ0;

  mem_wb_pipe #(.DATA_W(DW), .RD_W(RW), .SKID(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1.slave), .occupancy(occ1));
  mem_wb_pipe #(.DATA_W(DW), .RD_W(RW), .SKID(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0.slave), .occupancy(occ0));

  int errors = 0;
  int checks = 0;

  // Reference model: the entries each stage holds, oldest first
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q0[$];

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [RW-1:0] rd, input logic wr,
                       input logic ld, input logic [DW-1:0] alu,
                       input logic [DW-1:0] dm, input logic ordy, input logic fl);
    b1.in_valid = v;  b1.in_rd = rd;  b1.in_im_to_rf = wr;  b1.in_load = ld;
    b1.in_alu_data = alu;  b1.in_dm_data = dm;  b1.out_ready = ordy;
    b0.in_valid = v;  b0.in_rd = rd;  b0.in_im_to_rf = wr;  b0.in_load = ld;
    b0.in_alu_data = alu;  b0.in_dm_data = dm;  b0.out_ready = ordy;
    flush = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  // Model step for one edge: flush empties, else retire front then accept
  task automatic model_edge(input logic v, input logic [EW-1:0] e,
                            input logic ordy, input logic fl);
    logic r1, r0;
    r1 = (exp_q1.size() < 2);
    r0 = (exp_q0.size() == 0) || ordy;
    if (fl) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      if (exp_q1.size() > 0 && ordy) void'(exp_q1.pop_front());
      if (exp_q0.size() > 0 && ordy) void'(exp_q0.pop_front());
      if (v && r1) exp_q1.push_back(e);
      if (v && r0) exp_q0.push_back(e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(1'b1);
    #1;
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got=%b exp=0", b1.out_valid); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
    checks++; if (b1.out_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb1 got=%h exp=0", b1.out_wb_data); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy1 got=%b exp=1", b1.in_ready); end
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy0 got=%b exp=1", b0.in_ready); end
    checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL reset_occ0 got=%0d exp=0", occ0); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_through();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid1 got=%b exp=1", b1.out_valid); end
    checks++; if (b1.out_rd !== 5'd7) begin errors++; $display("FAIL pass_rd1 got=%0d exp=7", b1.out_rd); end
    checks++; if (b1.out_wb_data !== 32'h0000_1234) begin errors++; $display("FAIL pass_wb1 got=%h exp=00001234", b1.out_wb_data); end
    checks++; if (b0.out_rd !== 5'd7) begin errors++; $display("FAIL pass_rd0 got=%0d exp=7", b0.out_rd); end
    checks++; if (b0.out_wb_data !== 32'h0000_1234) begin errors++; $display("FAIL pass_wb0 got=%h exp=00001234", b0.out_wb_data); end
    idle(1'b1);
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid1 got=%b exp=0", b1.out_valid); end
    checks++; if ({b1.out_rd, b1.out_im_to_rf, b1.out_load} !== 7'd0) begin errors++; $display("FAIL bubble_ctl1 got=%h exp=0", {b1.out_rd, b1.out_im_to_rf, b1.out_load}); end
    checks++; if (b1.out_alu_data !== 32'h0000_1234) begin errors++; $display("FAIL bubble_hold1 got=%h exp=00001234", b1.out_alu_data); end
    checks++; if ({b0.out_rd, b0.out_im_to_rf, b0.out_load} !== 7'd0) begin errors++; $display("FAIL bubble_ctl0 got=%h exp=0", {b0.out_rd, b0.out_im_to_rf, b0.out_load}); end
  endtask

  task automatic test_load_select();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (b1.out_wb_data !== 32'h5555_5555) begin errors++; $display("FAIL load_wb1 got=%h exp=55555555", b1.out_wb_data); end
    checks++; if (b0.out_wb_data !== 32'h5555_5555) begin errors++; $display("FAIL load_wb0 got=%h exp=55555555", b0.out_wb_data); end
    checks++; if (b1.out_load !== 1'b1) begin errors++; $display("FAIL load_flag1 got=%b exp=1", b1.out_load); end
    idle(1'b1);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (occ1 !== 2'd1) begin errors++; $display("FAIL bp_occA got=%0d exp=1", occ1); end
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy0 got=%b exp=0", b0.in_ready); end
    drive(1'b1, 5'd2, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL bp_occB got=%0d exp=2", occ1); end
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdyB got=%b exp=0", b1.in_ready); end
    drive(1'b1, 5'd3, 1'b1, 1'b0, 32'h33, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL bp_occC got=%0d exp=2", occ1); end
    checks++; if (b1.out_rd !== 5'd1) begin errors++; $display("FAIL bp_rdA got=%0d exp=1", b1.out_rd); end
    drive(1'b1, 5'd3, 1'b1, 1'b0, 32'h33, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (b1.out_rd !== 5'd2) begin errors++; $display("FAIL bp_rdB got=%0d exp=2", b1.out_rd); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy_after got=%b exp=1", b1.in_ready); end
    @(negedge clk);
    checks++; if (b1.out_rd !== 5'd3) begin errors++; $display("FAIL bp_rdC got=%0d exp=3", b1.out_rd); end
    checks++; if (b1.out_wb_data !== 32'h33) begin errors++; $display("FAIL bp_wbC got=%h exp=33", b1.out_wb_data); end
    idle(1'b1);
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", b1.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 1'b0, 32'h55, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=2", occ1); end
    drive(1'b1, 5'd9, 1'b1, 1'b0, 32'h99, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid1 got=%b exp=0", b1.out_valid); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL flush_occ1 got=%0d exp=0", occ1); end
    checks++; if (b1.out_rd !== 5'd0 || b1.out_im_to_rf !== 1'b0) begin errors++; $display("FAIL flush_ctl1 got=%0d/%b exp=0/0", b1.out_rd, b1.out_im_to_rf); end
    checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL flush_occ0 got=%0d exp=0", occ0); end
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (b1.out_valid !== 1'b0 || b0.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got=%b/%b exp=0/0", b1.out_valid, b0.out_valid); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h66, 32'h77, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd8, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL areset_pre_occ got=%0d exp=2", occ1); end
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL areset_occ1 got=%0d exp=0", occ1); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid1 got=%b exp=0", b1.out_valid); end
    checks++; if (b1.out_wb_data !== 32'h0) begin errors++; $display("FAIL areset_wb1 got=%h exp=0", b1.out_wb_data); end
    checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL areset_occ0 got=%0d exp=0", occ0); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    @(negedge clk);
    checks++; if (occ1 !== 2'd0 || b1.in_ready !== 1'b1) begin errors++; $display("FAIL areset_after got=%0d/%b exp=0/1", occ1, b1.in_ready); end
  endtask

  task automatic test_stress();
    logic v, o, f, wr, ld;
    logic [RW-1:0] rd;
    logic [DW-1:0] alu, dm;
    logic [EW-1:0] e;
    logic [EW-1:0] obs_e[2];
    logic [EW-1:0] exp_e[2];
    logic          obs_v[2], obs_rdy[2], exp_rdy[2];
    logic [1:0]    obs_occ[2];
    logic [DW-1:0] obs_wb[2], exp_wb[2];
    int            exp_n[2];
    exp_q1.delete();
    exp_q0.delete();
    for (int i = 0; i < 1000; i++) begin
      v   = ($urandom_range(0, 9) < 6);
      o   = ($urandom_range(0, 9) < 6);
      f   = ($urandom_range(0, 29) == 0);
      rd  = RW'($urandom_range(0, 31));
      wr  = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 1));
      alu = $urandom;
      dm  = $urandom;
      e   = {rd, wr, ld, alu, dm};
      drive(v, rd, wr, ld, alu, dm, o, f);
      #1;
      obs_e[1] = {b1.out_rd, b1.out_im_to_rf, b1.out_load, b1.out_alu_data, b1.out_dm_data};
      obs_e[0] = {b0.out_rd, b0.out_im_to_rf, b0.out_load, b0.out_alu_data, b0.out_dm_data};
      obs_v[1] = b1.out_valid;  obs_v[0] = b0.out_valid;
      obs_rdy[1] = b1.in_ready; obs_rdy[0] = b0.in_ready;
      obs_occ[1] = occ1;        obs_occ[0] = occ0;
      obs_wb[1] = b1.out_wb_data; obs_wb[0] = b0.out_wb_data;
      exp_n[1] = exp_q1.size(); exp_n[0] = exp_q0.size();
      exp_e[1] = (exp_n[1] > 0) ? exp_q1[0] : '0;
      exp_e[0] = (exp_n[0] > 0) ? exp_q0[0] : '0;
      exp_rdy[1] = (exp_n[1] < 2);
      exp_rdy[0] = (exp_n[0] == 0) || o;
      for (int j = 0; j < 2; j++) begin
        exp_wb[j] = exp_e[j][2*DW] ? exp_e[j][DW-1:0] : exp_e[j][2*DW-1:DW];
        checks++;
        if (obs_occ[j] !== 2'(exp_n[j])) begin errors++; $display("FAIL stress_occ skid=%0d cyc=%0d got=%0d exp=%0d", j, i, obs_occ[j], exp_n[j]); end
        checks++;
        if (obs_v[j] !== (exp_n[j] > 0)) begin errors++; $display("FAIL stress_valid skid=%0d cyc=%0d got=%b exp=%b", j, i, obs_v[j], exp_n[j] > 0); end
        checks++;
        if (obs_rdy[j] !== exp_rdy[j]) begin errors++; $display("FAIL stress_ready skid=%0d cyc=%0d got=%b exp=%b", j, i, obs_rdy[j], exp_rdy[j]); end
        checks++;
        if (exp_n[j] > 0) begin
          if (obs_e[j] !== exp_e[j] || obs_wb[j] !== exp_wb[j]) begin errors++; $display("FAIL stress_entry skid=%0d cyc=%0d got=%h/%h exp=%h/%h", j, i, obs_e[j], obs_wb[j], exp_e[j], exp_wb[j]); end
        end else begin
          if (obs_e[j][EW-1 -: RW+2] !== '0) begin errors++; $display("FAIL stress_bubble skid=%0d cyc=%0d got=%h exp=0", j, i, obs_e[j][EW-1 -: RW+2]); end
        end
      end
      @(posedge clk);
      model_edge(v, e, o, f);
      @(negedge clk);
    end
    // Drain: everything not flushed must come out and leave the stage empty
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      model_edge(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
    end
    checks++; if (occ1 !== 2'd0 || occ0 !== 2'd0) begin errors++; $display("FAIL stress_drain got=%0d/%0d exp=0/0", occ1, occ0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle(1'b1);
    test_reset();
    test_pass_through();
    test_load_select();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32: width of ALU-result and data-memory-read payloads.
REQ-002 Parameter RD_W, default 5: destination-register index width.
REQ-003 Parameter SKID, default 1: 1 = two-entry skid-buffered stage; 0 = single-register stage.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 in_valid  in  1  upstream (MEM) entry present.
REQ-008 in_ready  out  1  stage accepts entry this cycle.
REQ-009 in_rd  in  RD_W  destination register.
REQ-010 in_im_to_rf  in  1  register-file write enable.
REQ-011 in_load  in  1  entry is a load.
REQ-012 in_alu_data  in  DATA_W  ALU result.
REQ-013 in_dm_data  in  DATA_W  data-memory read data.
REQ-014 out_valid  out  1  WB entry present.
REQ-015 out_ready  in  1  WB consumes entry this cycle.
REQ-016 out_rd, out_im_to_rf, out_load, out_alu_data, out_dm_data  out  as inputs  held entry fields.
REQ-017 out_wb_data  out  DATA_W  out_load ? out_dm_data : out_alu_data, combinational from held entry.
REQ-018 occupancy  out  2  number of held entries (0..2).

Function
REQ-019 Input transfer ("accept") occurs when in_valid && in_ready at a rising edge; output transfer ("retire") when out_valid && out_ready.
REQ-020 Main register (M) drives all out_* fields; out_valid = M valid.
REQ-021 SKID=1: in_ready = !S_valid, registered (no combinational path from out_ready).
REQ-022 SKID=1, edge update when flush=0: if !M_valid or out_ready, M loads S if S_valid, else the accepted input, else becomes empty; S clears.
REQ-023 SKID=1: if M_valid && !out_ready and an input is accepted, the input loads S; M holds.
REQ-024 SKID=0: no S; in_ready = !M_valid || out_ready (combinational); M loads accepted input, else empties on retire.
REQ-025 Latency: accepted entry appears on out_* the following cycle when M is empty or retiring; no entry lost, duplicated or reordered.
REQ-026 Simultaneous accept and retire with S empty: M replaced by the new entry, occupancy unchanged.
REQ-027 flush=1 at an edge: M and S both empty next cycle; any input presented that cycle is discarded; flush has priority over accept and retire.
REQ-028 When out_valid=0, out_rd, out_im_to_rf and out_load SHALL be 0 (bubble); out_alu_data/out_dm_data hold last value.
REQ-029 occupancy = M_valid + S_valid; never exceeds 1 when SKID=0.
REQ-030 Payload fields SHALL pass unmodified, full DATA_W/RD_W width, no truncation or extension.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, clear M_valid, S_valid, and all payload registers to 0.
REQ-032 During reset: out_valid=0, occupancy=0, out_wb_data=0; in_ready=1 (SKID=1) or 1 (SKID=0).
REQ-033 Reset asserted mid-transfer discards all held entries; first edge after rst_n rises behaves as empty stage.

Verification
REQ-034 Pass-through: out_ready=1, present rd=5'd7, im_to_rf=1, load=0, alu=32'h0000_1234 -> next cycle out_valid=1, out_rd=7, out_wb_data=32'h0000_1234.
REQ-035 Load select: load=1, alu=32'hAAAA_AAAA, dm=32'h5555_5555 -> out_wb_data=32'h5555_5555.
REQ-036 Backpressure (SKID=1): out_ready=0, accept A (rd=1) then B (rd=2) -> occupancy=2, in_ready=0, C held upstream; raise out_ready -> A, B, C retire in order, rd 1,2,3.
REQ-037 Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle out_valid=0, occupancy=0, out_rd=0, out_im_to_rf=0; flushed input never appears.
REQ-038 Async reset: assert rst_n=0 mid-cycle with occupancy=2 -> out_valid=0 and occupancy=0 before the next clk edge.
REQ-039 Random stress both SKID values: 1000 cycles random in_valid/out_ready/flush against scoreboard -> zero mismatches, zero drops outside flush.
